// File: rtl/isqrt_seq_pkg.sv
// isqrt_seq_pkg
// Shared definitions for the iterative integer square-root unit: the FSM
// state encoding, the default radicand width and the helper functions that
// derive the root/remainder widths from a radicand width. The upstream
// multiplier uses the same helpers so both blocks agree on the product width.
package isqrt_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  // Root is half the radicand width.
  function automatic int rootWidth(input int width);
    return width / 2;
  endfunction

  // Remainder can reach 2*root, so it needs one bit more than the root.
  function automatic int remWidth(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_seq_if.sv
// isqrt_seq_if
// Start/busy handshake bundle between a requester and the square-root unit.
//   x_bi   : unsigned radicand, sampled when start is accepted
//   start  : request, honoured only while the unit is idle
//   busy_o : unit is iterating
//   done_o : one-cycle pulse when y_bo/r_bo are refreshed
//   y_bo   : floor(sqrt(x))
//   r_bo   : x - y*y
// master = requester side, slave = square-root unit side.
interface isqrt_seq_if
  import isqrt_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int RW   = rootWidth(WIDTH);
  localparam int REMW = remWidth(WIDTH);

  logic [WIDTH-1:0] x_bi;
  logic             start;
  logic             busy_o;
  logic             done_o;
  logic [RW-1:0]    y_bo;
  logic [REMW-1:0]  r_bo;

  modport master (
    output x_bi, start,
    input  busy_o, done_o, y_bo, r_bo
  );

  modport slave (
    input  x_bi, start,
    output busy_o, done_o, y_bo, r_bo
  );

endinterface

// File: rtl/isqrt_seq_step.sv
// isqrt_step
// One iteration of the restoring bit-pair square root. Purely combinational
// so the compare/subtract datapath can be exercised on its own.
//   rem_i/root_i/mask_i : current partial remainder, root and bit mask
//   rem_o/root_o        : values after this iteration
module isqrt_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] root_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] root_o
);

  logic [WIDTH-1:0] trial;

  // The mask bit never overlaps the set bits of root, so OR is the same as
  // adding it. Subtracting only when rem >= trial keeps rem non-negative.
  always_comb begin
    trial  = root_i | mask_i;
    rem_o  = rem_i;
    root_o = root_i >> 1;
    if (rem_i >= trial) begin
      rem_o  = rem_i - trial;
      root_o = (root_i >> 1) | mask_i;
    end
  end

endmodule

// File: rtl/isqrt_seq.sv
// isqrt_seq
// Iterative integer square root, one result bit per clock.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : isqrt_seq_if slave modport (x_bi, start, busy_o, done_o, y_bo, r_bo)
// A start accepted in IDLE runs WIDTH/2 WORK cycles; the final WORK edge
// loads y_bo/r_bo, pulses done_o and returns to IDLE so a new start can be
// taken in the same cycle done_o is high.
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  isqrt_seq_if.slave  bus
);

  localparam int RW    = rootWidth(WIDTH);
  localparam int REMW  = remWidth(WIDTH);
  localparam int CTR_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] MASK_INIT = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH - 2);
  localparam logic [CTR_W-1:0] LAST_STEP = CTR_W'(RW - 1);

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] root_q;
  logic [WIDTH-1:0] mask_q;
  logic [CTR_W-1:0] ctr_q;
  logic [RW-1:0]    y_q;
  logic [REMW-1:0]  r_q;
  logic             done_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] root_d;

  isqrt_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .mask_i (mask_q),
    .rem_o  (rem_d),
    .root_o (root_d)
  );

  // Control FSM, iteration registers and result registers. done_q defaults
  // low every edge so it is a single-cycle pulse; the results are taken from
  // the step outputs on the last WORK edge, where the upper root half is zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      root_q  <= '0;
      mask_q  <= '0;
      ctr_q   <= '0;
      y_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rem_q   <= bus.x_bi;
            root_q  <= '0;
            mask_q  <= MASK_INIT;
            ctr_q   <= '0;
            state_q <= WORK;
          end
        end
        WORK: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          mask_q <= mask_q >> 2;
          ctr_q  <= ctr_q + 1'b1;
          if (ctr_q == LAST_STEP) begin
            y_q     <= root_d[RW-1:0];
            r_q     <= rem_d[REMW-1:0];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state_q == WORK);
  assign bus.done_o = done_q;
  assign bus.y_bo   = y_q;
  assign bus.r_bo   = r_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq
// Self-checking bench for isqrt_seq. Each accepted request pushes its
// expected root/remainder (from an independent search model) into a
// scoreboard; a monitor pops and compares on every done_o pulse.
module tb_isqrt_seq;
  import isqrt_seq_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
  localparam int RW    = rootWidth(WIDTH);

  typedef struct {
    int x;
    int y;
    int r;
  } expect_t;

  logic    clk = 1'b0;
  logic    reset;
  expect_t scoreboard[$];
  expect_t monExp;
  int      checkCount = 0;
  int      passCount  = 0;
  int      doneCount  = 0;

  always #5 clk = ~clk;

  isqrt_seq_if #(.WIDTH(WIDTH)) bus ();

  isqrt_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: smallest y whose successor squared exceeds x.
  function automatic int refRoot(input int x);
    int y = 0;
    while ((y + 1) * (y + 1) <= x) y++;
    return y;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Drives one start request; called just after a falling edge. When
  // expectResult is set the model's answer is queued for the monitor.
  task automatic applyStimulus(input int x, input bit expectResult);
    expect_t e;
    bus.x_bi  = x[WIDTH-1:0];
    bus.start = 1'b1;
    if (expectResult) begin
      e.x = x;
      e.y = refRoot(x);
      e.r = x - e.y * e.y;
      scoreboard.push_back(e);
    end
  endtask

  // Waits (bounded) for done_o, counting falling edges that see busy_o.
  task automatic waitDone(output int busyCycles);
    int guard = 0;
    busyCycles = 0;
    while (bus.done_o !== 1'b1 && guard < 40) begin
      if (bus.busy_o === 1'b1) busyCycles++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) checkOutput("doneTimeout", 0, 1);
  endtask

  // Full operation with latency and pulse-width checks; x_bi is scrambled
  // during WORK to show it is not resampled.
  task automatic runOp(input int x);
    int bc;
    applyStimulus(x, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_bi  = WIDTH'($urandom);
    waitDone(bc);
    checkOutput($sformatf("busyCycles(x=%0d)", x), bc, RW);
    checkOutput("busyAtDone", {31'd0, bus.busy_o}, 0);
    @(negedge clk);
    checkOutput("donePulseWidth", {31'd0, bus.done_o}, 0);
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest request.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done_o === 1'b1) begin
      doneCount++;
      if (scoreboard.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        monExp = scoreboard.pop_front();
        checkOutput($sformatf("y(x=%0d)", monExp.x), 32'(bus.y_bo), monExp.y);
        checkOutput($sformatf("r(x=%0d)", monExp.x), 32'(bus.r_bo), monExp.r);
        checkOutput($sformatf("bounds(x=%0d)", monExp.x),
                    {31'd0, (int'(bus.y_bo) * int'(bus.y_bo) <= monExp.x) &&
                            (monExp.x < (int'(bus.y_bo) + 1) * (int'(bus.y_bo) + 1))}, 1);
      end
    end
  end

  initial begin
    int bc;
    int d0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.x_bi  = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'd0, bus.busy_o}, 0);
    checkOutput("resetDone", {31'd0, bus.done_o}, 0);
    checkOutput("resetY", 32'(bus.y_bo), 0);
    checkOutput("resetR", 32'(bus.r_bo), 0);
    reset = 1'b1;
    @(negedge clk);

    // Perfect squares, zero and remainder cases
    runOp(0);
    runOp(144);
    runOp(65025);
    runOp(2);
    runOp(65535);
    runOp(1000);

    // Reset three edges into WORK: outputs clear at once, no late done
    applyStimulus(1000, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'd0, bus.busy_o}, 0);
    checkOutput("midResetDone", {31'd0, bus.done_o}, 0);
    checkOutput("midResetY", 32'(bus.y_bo), 0);
    checkOutput("midResetR", 32'(bus.r_bo), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    d0 = doneCount;
    repeat (15) @(negedge clk);
    checkOutput("noDoneAfterReset", doneCount, d0);
    runOp(144);

    // Start while busy is ignored
    d0 = doneCount;
    applyStimulus(400, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(9, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(bc);
    repeat (15) @(negedge clk);
    checkOutput("singleDoneWhileBusy", doneCount, d0 + 1);

    // Back-to-back: new start accepted in the done_o cycle
    applyStimulus(100, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(bc);
    checkOutput("b2bIdleAtDone", {31'd0, bus.busy_o}, 0);
    applyStimulus(81, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2bBusyNext", {31'd0, bus.busy_o}, 1);
    waitDone(bc);
    checkOutput("b2bBusyCycles", bc, RW);
    @(negedge clk);

    // Randomised sweep including both extremes
    runOp(0);
    runOp(65535);
    for (int i = 0; i < 998; i++) runOp(int'($urandom_range(0, 65535)));

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", scoreboard.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
